// File: rtl/alu_issue_unit.sv
// Sequential issue stage in front of the combinational ALU: registers one request,
// drives the ALU from it and queues result/zero/tag in a small response FIFO.
// Optional illegal-opcode checking is enabled by defining ALU_ISSUE_ERRCHK_EN.
module alu_issue_unit #(
    parameter int DATA_W    = 32,
    parameter int OP_W      = 3,
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              busy
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(RSP_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Held low through reset and for one edge after it so req_ready reads 0 in reset.
    logic run_reg;

    logic [OP_W-1:0]   op_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [TAG_W-1:0]  tag_reg;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    logic fifo_full;
    logic pop;
    logic capture;
    logic accept;

    logic [DATA_W-1:0] push_result;
    logic              push_zero;
    logic [RSP_DEPTH-1:0] wr_en;

    logic [DATA_W-1:0] res_mem [RSP_DEPTH];
    logic              zero_mem [RSP_DEPTH];
    logic [TAG_W-1:0]  tag_mem [RSP_DEPTH];

    assign fifo_full = (count_reg == DEPTH_C);
    assign pop       = rsp_ready && (count_reg != '0);
    assign capture   = (state_reg != IDLE) && (!fifo_full || pop);
    assign req_ready = run_reg && ((state_reg == IDLE) || capture);
    assign accept    = req_valid && req_ready;

`ifdef ALU_ISSUE_ERRCHK_EN
    logic illegal_op;
    logic push_err;
    logic err_mem [RSP_DEPTH];

    assign illegal_op  = (op_reg == {OP_W{1'b1}});
    assign push_result = illegal_op ? '0 : alu_result;
    assign push_zero   = illegal_op | alu_zero;
    assign push_err    = illegal_op;
`else
    assign push_result = alu_result;
    assign push_zero   = alu_zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = EXEC;
            end
            EXEC, STALL: begin
                if (capture) state_next = accept ? EXEC : IDLE;
                else         state_next = STALL;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage registers double as the ALU drive; cleared whenever the stage empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg  <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            tag_reg <= '0;
        end else if (accept) begin
            op_reg  <= req_op;
            a_reg   <= req_a;
            b_reg   <= req_b;
            tag_reg <= req_tag;
        end else if (capture) begin
            op_reg  <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            tag_reg <= '0;
        end
    end

    assign alu_op = op_reg;
    assign alu_a  = a_reg;
    assign alu_b  = b_reg;

    generate
        for (genvar gi = 0; gi < RSP_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = capture && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < RSP_DEPTH; i++) begin
            if (wr_en[i]) begin
                res_mem[i]  <= push_result;
                zero_mem[i] <= push_zero;
                tag_mem[i]  <= tag_reg;
`ifdef ALU_ISSUE_ERRCHK_EN
                err_mem[i]  <= push_err;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (capture) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({capture, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head fields are masked while empty so storage contents never leak out.
    assign rsp_valid  = (count_reg != '0);
    assign rsp_result = rsp_valid ? res_mem[rd_ptr_reg] : '0;
    assign rsp_zero   = rsp_valid && zero_mem[rd_ptr_reg];
    assign rsp_tag    = rsp_valid ? tag_mem[rd_ptr_reg] : '0;
`ifdef ALU_ISSUE_ERRCHK_EN
    assign rsp_err    = rsp_valid && err_mem[rd_ptr_reg];
`else
    assign rsp_err    = 1'b0;
`endif

    assign busy = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a small behavioural ALU attached to its ALU ports.
module tb_alu_issue_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_tag;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic        busy;

    int checks_total;
    int checks_passed;

    alu_issue_unit #(
        .DATA_W(32), .OP_W(3), .TAG_W(4), .RSP_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
        .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; opcode 7 gives a+b+1 so an unchecked pass-through is visible.
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = {31'd0, alu_a < alu_b};
            3'd6: alu_result = alu_b << alu_a[4:0];
            default: alu_result = alu_a + alu_b + 32'd1;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    endtask

    task automatic chk1(input string name, input logic obs, input logic exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%b expected=%b", name, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        req_tag   = 4'd0;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        idle_req();

        // Reset state
        sample();
        chk1 ("rst_rsp_valid", rsp_valid, 1'b0);
        chk1 ("rst_busy", busy, 1'b0);
        chk32("rst_alu_a", alu_a, 32'd0);
        chk1 ("rst_req_ready", req_ready, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        sample();
        chk1("post_rst_req_ready", req_ready, 1'b1);

        // Single ADD 5+7 tag 3
        next_cycle();
        drive(3'd0, 32'd5, 32'd7, 4'd3);
        sample();
        chk1("add_req_ready", req_ready, 1'b1);
        next_cycle();
        idle_req();
        sample();
        chk32("add_alu_a", alu_a, 32'd5);
        chk32("add_alu_b", alu_b, 32'd7);
        chk1 ("add_busy_exec", busy, 1'b1);
        chk1 ("add_rsp_not_yet", rsp_valid, 1'b0);
        next_cycle();
        sample();
        chk1 ("add_rsp_valid", rsp_valid, 1'b1);
        chk32("add_result", rsp_result, 32'd12);
        chk1 ("add_zero", rsp_zero, 1'b0);
        chk32("add_tag", 32'(rsp_tag), 32'd3);
        chk1 ("add_err", rsp_err, 1'b0);
        chk32("add_alu_a_cleared", alu_a, 32'd0);
        next_cycle();
        sample();
        chk1("add_rsp_popped", rsp_valid, 1'b0);
        chk1("add_busy_done", busy, 1'b0);

        // SUB to zero
        next_cycle();
        drive(3'd1, 32'h10, 32'h10, 4'd5);
        next_cycle();
        idle_req();
        next_cycle();
        sample();
        chk1 ("sub_rsp_valid", rsp_valid, 1'b1);
        chk32("sub_result", rsp_result, 32'd0);
        chk1 ("sub_zero", rsp_zero, 1'b1);
        chk32("sub_tag", 32'(rsp_tag), 32'd5);

        // Back-to-back: request j has a=10*j, b=1 -> result 10*j+1
        next_cycle();
        for (int j = 0; j < 6; j++) begin
            if (j < 4) drive(3'd0, 32'(10 * j), 32'd1, 4'(j));
            else       idle_req();
            sample();
            if (j < 4) chk1("b2b_req_ready", req_ready, 1'b1);
            if (j >= 2) begin
                chk1 ("b2b_rsp_valid", rsp_valid, 1'b1);
                chk32("b2b_tag", 32'(rsp_tag), 32'(j - 2));
                chk32("b2b_result", rsp_result, 32'(10 * (j - 2) + 1));
            end
            next_cycle();
        end
        sample();
        chk1("b2b_busy_done", busy, 1'b0);

        // Backpressure: tags 8..11, a=100+i, b=i -> result 100+2i
        next_cycle();
        rsp_ready = 1'b0;
        drive(3'd0, 32'd100, 32'd0, 4'd8);
        sample();
        chk1("bp_ready0", req_ready, 1'b1);
        next_cycle();
        drive(3'd0, 32'd101, 32'd1, 4'd9);
        sample();
        chk1("bp_ready1", req_ready, 1'b1);
        next_cycle();
        drive(3'd0, 32'd102, 32'd2, 4'd10);
        sample();
        chk1("bp_ready2", req_ready, 1'b1);
        next_cycle();
        drive(3'd0, 32'd103, 32'd3, 4'd11);
        sample();
        chk1 ("bp_ready3_blocked", req_ready, 1'b0);
        chk32("bp_alu_a_exec", alu_a, 32'd102);
        next_cycle();
        sample();
        chk1 ("bp_stall_ready", req_ready, 1'b0);
        chk32("bp_stall_alu_a", alu_a, 32'd102);
        chk32("bp_stall_alu_b", alu_b, 32'd2);
        chk1 ("bp_stall_rsp_valid", rsp_valid, 1'b1);
        chk32("bp_stall_head_tag", 32'(rsp_tag), 32'd8);
        next_cycle();
        rsp_ready = 1'b1;
        sample();
        chk1 ("bp_release_ready", req_ready, 1'b1);
        chk32("bp_drain_tag0", 32'(rsp_tag), 32'd8);
        chk32("bp_drain_res0", rsp_result, 32'd100);
        next_cycle();
        idle_req();
        for (int k = 1; k < 4; k++) begin
            sample();
            chk1 ("bp_drain_valid", rsp_valid, 1'b1);
            chk32("bp_drain_tag", 32'(rsp_tag), 32'(8 + k));
            chk32("bp_drain_res", rsp_result, 32'(100 + 2 * k));
            next_cycle();
        end
        sample();
        chk1("bp_empty", rsp_valid, 1'b0);
        chk1("bp_busy_done", busy, 1'b0);

        // Reset while stalled with a full FIFO
        next_cycle();
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(3'd0, 32'(200 + k), 32'd1, 4'(k));
            next_cycle();
        end
        idle_req();
        next_cycle();
        sample();
        chk1("mid_busy_before", busy, 1'b1);
        chk1("mid_full_valid", rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1 ("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk1 ("mid_rst_busy", busy, 1'b0);
        chk32("mid_rst_alu_a", alu_a, 32'd0);
        chk32("mid_rst_alu_b", alu_b, 32'd0);
        chk32("mid_rst_rsp_result", rsp_result, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        next_cycle();
        drive(3'd2, 32'hF0, 32'h3C, 4'd7);
        sample();
        chk1("post_mid_req_ready", req_ready, 1'b1);
        next_cycle();
        idle_req();
        next_cycle();
        sample();
        chk1 ("post_mid_rsp_valid", rsp_valid, 1'b1);
        chk32("post_mid_result", rsp_result, 32'h30);
        chk32("post_mid_tag", 32'(rsp_tag), 32'd7);
        next_cycle();

        // Opcode 3'b111 with a=1, b=2
        drive(3'd7, 32'd1, 32'd2, 4'd1);
        next_cycle();
        idle_req();
        next_cycle();
        sample();
        chk1 ("ill_rsp_valid", rsp_valid, 1'b1);
        chk32("ill_tag", 32'(rsp_tag), 32'd1);
`ifdef ALU_ISSUE_ERRCHK_EN
        chk1 ("ill_err", rsp_err, 1'b1);
        chk32("ill_result", rsp_result, 32'd0);
        chk1 ("ill_zero", rsp_zero, 1'b1);
`else
        chk1 ("ill_err", rsp_err, 1'b0);
        chk32("ill_result", rsp_result, 32'd4);
        chk1 ("ill_zero", rsp_zero, 1'b0);
`endif
        next_cycle();
        sample();
        chk1("final_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
